// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
// Holds the fetch FSM encoding, the buffered {instr, pc} entry and RV32I opcode values.
// No logic; imported by instr_fetch and fetch_fifo.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;   // addi x0, x0, 0
    localparam logic [31:0] PC_STEP   = 32'd4;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // reset, or no buffer space for another word
        REQ   = 2'd1,   // imemReq high, waiting for grant
        WAIT  = 2'd2,   // granted, response expected
        DRAIN = 2'd3    // granted request was redirected away; swallow its response
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: DEPTH-entry FIFO of {instr, pc}; ports push/push_dat, pop, flush, head_dat, count.
// Latency: a push is visible at the head on the cycle after it is written (registered storage).
// Backpressure: push is accepted when not full or when a pop happens in the same cycle; flush wins over both.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  fetch_entry_t  push_dat,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  head_dat,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop_ok;
    logic          push_ok;

    assign pop_ok   = pop && (count != '0);
    assign push_ok  = push && ((count < CW'(DEPTH)) || pop_ok);
    assign head_dat = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok)      count <= count + 1'b1;
            else if (pop_ok && !push_ok) count <= count - 1'b1;
        end
    end

    // Storage needs no reset: count gates everything read from it.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, keeps one imem request in flight, buffers words for decode.
// Latency: response to instrValid is one cycle (registered buffer); opcode/funct3/funct7 are split from instr.
// Backpressure: instrValid/instrReady; no request issues unless buffer occupancy + outstanding < FIFO_DEPTH.
// Ports: imemReq/imemAddr/imemGnt/imemRspValid/imemRspData to memory; instr* and fields to decode;
// redirectValid/redirectPc flush the buffer and retarget or drop the current fetch.
// Optional macro FETCH_PERF_EN adds fetchCount (buffer pushes) and stallCount (empty, non-redirect cycles).
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemGnt,
    input  logic        imemRspValid,
    input  logic [31:0] imemRspData,
    output logic        instrValid,
    input  logic        instrReady,
    output logic [31:0] instr,
    output logic [31:0] instrPc,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    input  logic        redirectValid,
`ifdef FETCH_PERF_EN
    input  logic [31:0] redirectPc,
    output logic [31:0] fetchCount,
    output logic [31:0] stallCount
`else
    input  logic [31:0] redirectPc
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t  state;
    fetch_state_t  state_nxt;
    logic [31:0]   fetch_pc;
    logic [31:0]   fetch_pc_nxt;
    logic [31:0]   redirect_tgt;
    logic [CW-1:0] fifo_count;
    fetch_entry_t  head;
    fetch_entry_t  rsp_entry;
    logic          head_vld;
    logic          fifo_push;
    logic          fifo_pop;
    logic          space_now;
    logic          space_after_rsp;
    logic          unused_redirect_lsbs;

    assign redirect_tgt         = {redirectPc[31:2], 2'b00};
    assign unused_redirect_lsbs = ^redirectPc[1:0];

    assign head_vld  = (fifo_count != '0);
    // A redirect flushes the buffer, so a coincident pop or push has no effect.
    assign fifo_pop  = head_vld && instrReady && !redirectValid;
    assign fifo_push = (state == WAIT) && imemRspValid && !redirectValid;
    assign rsp_entry = '{instr: imemRspData, pc: fetch_pc - PC_STEP};

    // In WAIT the outstanding slot becomes a buffer entry; another request fits
    // only if the buffer will still have room after this cycle's push and pop.
    assign space_now       = (fifo_count < CW'(FIFO_DEPTH));
    assign space_after_rsp = fifo_pop || (fifo_count < CW'(FIFO_DEPTH - 1));

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        if (redirectValid) begin
            fetch_pc_nxt = redirect_tgt;
            case (state)
                IDLE:    state_nxt = REQ;
                REQ:     state_nxt = imemGnt ? DRAIN : REQ;       // ungranted request just retargets
                WAIT:    state_nxt = imemRspValid ? REQ : DRAIN;  // response this cycle is discarded here
                DRAIN:   state_nxt = imemRspValid ? REQ : DRAIN;
                default: state_nxt = IDLE;
            endcase
        end else begin
            case (state)
                IDLE: begin
                    if (space_now) state_nxt = REQ;
                end
                REQ: begin
                    if (imemGnt) begin
                        state_nxt    = WAIT;
                        fetch_pc_nxt = next_pc(fetch_pc);
                    end
                end
                WAIT: begin
                    if (imemRspValid) state_nxt = space_after_rsp ? REQ : IDLE;
                end
                DRAIN: begin
                    if (imemRspValid) state_nxt = REQ;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
        end
    end

    // fetch_pc has already advanced past the granted word, so the word's own PC is fetch_pc - 4.
    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .push_dat (rsp_entry),
        .pop      (fifo_pop),
        .flush    (redirectValid),
        .head_dat (head),
        .count    (fifo_count)
    );

    assign imemReq    = (state == REQ);
    assign imemAddr   = fetch_pc;
    assign instrValid = head_vld;
    assign instr      = head_vld ? head.instr : NOP_INSTR;
    assign instrPc    = head_vld ? head.pc : 32'h0;
    assign opcode     = instr[6:0];
    assign funct3     = instr[14:12];
    assign funct7     = instr[31:25];

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetchCount <= '0;
            stallCount <= '0;
        end else begin
            if (fifo_push)                  fetchCount <= fetchCount + 32'd1;
            if (!head_vld && !redirectValid) stallCount <= stallCount + 32'd1;
        end
    end
`endif

endmodule
